// File: rtl/bp_fe_icache_req_arbiter.sv
// Arbitrates I$ miss requests from two fetch ports onto one cache-engine channel,
// merges same-block cached misses, and steers engine returns to the owning port(s).
module bp_fe_icache_req_arbiter #(
  parameter int paddr_width_p    = 56,
  parameter int block_width_p    = 512,
  parameter int req_width_p      = 64,
  parameter int metadata_width_p = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic [req_width_p-1:0]      req0_i,
  input  logic [paddr_width_p-1:0]    req0_paddr_i,
  input  logic                        req0_uncached_i,
  input  logic                        req0_v_i,
  output logic                        req0_yumi_o,
  input  logic [metadata_width_p-1:0] req0_metadata_i,
  input  logic                        req0_metadata_v_i,

  input  logic [req_width_p-1:0]      req1_i,
  input  logic [paddr_width_p-1:0]    req1_paddr_i,
  input  logic                        req1_uncached_i,
  input  logic                        req1_v_i,
  output logic                        req1_yumi_o,
  input  logic [metadata_width_p-1:0] req1_metadata_i,
  input  logic                        req1_metadata_v_i,

  output logic                        crit_tag0_o,
  output logic                        crit_data0_o,
  output logic                        complete0_o,
  output logic                        crit_tag1_o,
  output logic                        crit_data1_o,
  output logic                        complete1_o,

  output logic [req_width_p-1:0]      cache_req_o,
  output logic                        cache_req_v_o,
  input  logic                        cache_req_yumi_i,
  input  logic                        cache_req_busy_i,
  output logic [metadata_width_p-1:0] cache_req_metadata_o,
  output logic                        cache_req_metadata_v_o,
  input  logic                        cache_req_critical_tag_i,
  input  logic                        cache_req_critical_data_i,
  input  logic                        cache_req_complete_i,

  output logic                        error_o
);

  localparam int block_offset_lp = $clog2(block_width_p/8);

  typedef enum logic [1:0] {e_ready, e_meta, e_wait} state_e;

  state_e     state_r, state_n;
  logic [1:0] owner_r, owner_n;
  logic       lru_r, lru_n;
  logic       error_r;

  logic both_v, any_v, sel, merge, grant_ok, primary, ret_any;

  // Offset bits only select bytes within a block; they never affect merging.
  logic unused_offset;
  assign unused_offset = ^{req0_paddr_i[block_offset_lp-1:0], req1_paddr_i[block_offset_lp-1:0]};

  assign both_v   = req0_v_i & req1_v_i;
  assign any_v    = req0_v_i | req1_v_i;
  assign sel      = both_v ? ~lru_r : req1_v_i;
  assign merge    = both_v & ~req0_uncached_i & ~req1_uncached_i
                  & (req0_paddr_i[paddr_width_p-1:block_offset_lp]
                     == req1_paddr_i[paddr_width_p-1:block_offset_lp]);
  assign grant_ok = ~cache_req_busy_i & any_v;
  assign primary  = ~owner_r[0];
  assign ret_any  = cache_req_critical_tag_i | cache_req_critical_data_i | cache_req_complete_i;

  assign cache_req_o          = sel ? req1_i : req0_i;
  assign cache_req_metadata_o = primary ? req1_metadata_i : req0_metadata_i;
  assign error_o              = error_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_ready;
      owner_r <= '0;
      lru_r   <= 1'b1;
      error_r <= 1'b0;
    end else begin
      state_r <= state_n;
      owner_r <= owner_n;
      lru_r   <= lru_n;
      // Returns outside e_wait have no owner to go to; flag them permanently.
      error_r <= error_r | ((state_r != e_wait) & ret_any);
    end
  end

  always_comb begin
    state_n                = state_r;
    owner_n                = owner_r;
    lru_n                  = lru_r;
    cache_req_v_o          = 1'b0;
    req0_yumi_o            = 1'b0;
    req1_yumi_o            = 1'b0;
    cache_req_metadata_v_o = 1'b0;
    crit_tag0_o            = 1'b0;
    crit_data0_o           = 1'b0;
    complete0_o            = 1'b0;
    crit_tag1_o            = 1'b0;
    crit_data1_o           = 1'b0;
    complete1_o            = 1'b0;

    case (state_r)
      e_ready: begin
        if (grant_ok) begin
          cache_req_v_o = 1'b1;
          req0_yumi_o   = cache_req_yumi_i & (merge | ~sel);
          req1_yumi_o   = cache_req_yumi_i & (merge | sel);
          if (cache_req_yumi_i) begin
            owner_n = merge ? 2'b11 : (sel ? 2'b10 : 2'b01);
            lru_n   = merge ? ~lru_r : sel;
            state_n = e_meta;
          end
        end
      end
      e_meta: begin
        cache_req_metadata_v_o = primary ? req1_metadata_v_i : req0_metadata_v_i;
        if (cache_req_metadata_v_o) state_n = e_wait;
      end
      e_wait: begin
        crit_tag0_o  = cache_req_critical_tag_i  & owner_r[0];
        crit_data0_o = cache_req_critical_data_i & owner_r[0];
        complete0_o  = cache_req_complete_i      & owner_r[0];
        crit_tag1_o  = cache_req_critical_tag_i  & owner_r[1];
        crit_data1_o = cache_req_critical_data_i & owner_r[1];
        complete1_o  = cache_req_complete_i      & owner_r[1];
        if (cache_req_complete_i) begin
          owner_n = '0;
          state_n = e_ready;
        end
      end
      default: state_n = e_ready;
    endcase
  end

endmodule

// File: tb/tb_bp_fe_icache_req_arbiter.sv
// Directed bench for bp_fe_icache_req_arbiter: grant owner masks are predicted
// by a small model, queued at stimulus time and checked against the steered completes.
module tb_bp_fe_icache_req_arbiter;
  localparam int PW = 56;
  localparam int RW = 64;
  localparam int MW = 8;

  logic clk = 1'b0;
  logic reset_i;
  logic [RW-1:0] req0_i, req1_i;
  logic [PW-1:0] req0_paddr_i, req1_paddr_i;
  logic req0_uncached_i, req1_uncached_i, req0_v_i, req1_v_i, req0_yumi_o, req1_yumi_o;
  logic [MW-1:0] req0_metadata_i, req1_metadata_i;
  logic req0_metadata_v_i, req1_metadata_v_i;
  logic crit_tag0_o, crit_data0_o, complete0_o, crit_tag1_o, crit_data1_o, complete1_o;
  logic [RW-1:0] cache_req_o;
  logic cache_req_v_o, cache_req_yumi_i, cache_req_busy_i;
  logic [MW-1:0] cache_req_metadata_o;
  logic cache_req_metadata_v_o;
  logic cache_req_critical_tag_i, cache_req_critical_data_i, cache_req_complete_i;
  logic error_o;

  bp_fe_icache_req_arbiter #(
    .paddr_width_p(PW), .block_width_p(512), .req_width_p(RW), .metadata_width_p(MW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req0_i(req0_i), .req0_paddr_i(req0_paddr_i), .req0_uncached_i(req0_uncached_i),
    .req0_v_i(req0_v_i), .req0_yumi_o(req0_yumi_o),
    .req0_metadata_i(req0_metadata_i), .req0_metadata_v_i(req0_metadata_v_i),
    .req1_i(req1_i), .req1_paddr_i(req1_paddr_i), .req1_uncached_i(req1_uncached_i),
    .req1_v_i(req1_v_i), .req1_yumi_o(req1_yumi_o),
    .req1_metadata_i(req1_metadata_i), .req1_metadata_v_i(req1_metadata_v_i),
    .crit_tag0_o(crit_tag0_o), .crit_data0_o(crit_data0_o), .complete0_o(complete0_o),
    .crit_tag1_o(crit_tag1_o), .crit_data1_o(crit_data1_o), .complete1_o(complete1_o),
    .cache_req_o(cache_req_o), .cache_req_v_o(cache_req_v_o),
    .cache_req_yumi_i(cache_req_yumi_i), .cache_req_busy_i(cache_req_busy_i),
    .cache_req_metadata_o(cache_req_metadata_o), .cache_req_metadata_v_o(cache_req_metadata_v_o),
    .cache_req_critical_tag_i(cache_req_critical_tag_i),
    .cache_req_critical_data_i(cache_req_critical_data_i),
    .cache_req_complete_i(cache_req_complete_i),
    .error_o(error_o)
  );

  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [1:0] exp_q[$];
  logic lru_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_i = '0; req1_i = '0; req0_paddr_i = '0; req1_paddr_i = '0;
    req0_uncached_i = 0; req1_uncached_i = 0; req0_v_i = 0; req1_v_i = 0;
    req0_metadata_i = '0; req1_metadata_i = '0; req0_metadata_v_i = 0; req1_metadata_v_i = 0;
    cache_req_yumi_i = 0; cache_req_busy_i = 0;
    cache_req_critical_tag_i = 0; cache_req_critical_data_i = 0; cache_req_complete_i = 0;
  endtask

  task automatic do_reset();
    reset_i = 1;
    idle_inputs();
    tick();
    tick();
    reset_i = 0;
    lru_m = 1'b1;
    exp_q.delete();
  endtask

  task automatic run_txn(input logic v0, input logic v1, input logic [PW-1:0] a0,
                         input logic [PW-1:0] a1, input logic u0, input logic u1,
                         input int unsigned busy_cyc);
    logic both, sel, merge;
    logic [1:0] mask, got;
    logic [RW-1:0] exp_req;
    both    = v0 & v1;
    sel     = both ? ~lru_m : v1;
    merge   = both & ~u0 & ~u1 & (a0[PW-1:6] == a1[PW-1:6]);
    mask    = merge ? 2'b11 : (sel ? 2'b10 : 2'b01);
    exp_req = sel ? {8'hB1, a1} : {8'hA0, a0};
    exp_q.push_back(mask);

    req0_i = {8'hA0, a0}; req1_i = {8'hB1, a1};
    req0_paddr_i = a0; req1_paddr_i = a1;
    req0_uncached_i = u0; req1_uncached_i = u1;
    req0_v_i = v0; req1_v_i = v1;
    cache_req_yumi_i = 1;
    cache_req_busy_i = (busy_cyc > 0);
    req0_metadata_v_i = 1;
    for (int i = 0; i < int'(busy_cyc); i++) begin
      @(negedge clk);
      chk("busy_v", 64'(cache_req_v_o), 64'd0);
      chk("busy_yumi", 64'({req1_yumi_o, req0_yumi_o}), 64'd0);
      tick();
    end
    cache_req_busy_i = 0;

    @(negedge clk);
    chk("grant_v", 64'(cache_req_v_o), 64'd1);
    chk("grant_req", 64'(cache_req_o), 64'(exp_req));
    chk("grant_yumi", 64'({req1_yumi_o, req0_yumi_o}), 64'(mask));
    chk("meta_early", 64'(cache_req_metadata_v_o), 64'd0);
    tick();
    lru_m = merge ? ~lru_m : sel;

    req0_v_i = 0; req1_v_i = 0; cache_req_yumi_i = 0;
    req0_metadata_i = 8'h5A; req1_metadata_i = 8'hC3;
    req0_metadata_v_i = 1; req1_metadata_v_i = 1;
    @(negedge clk);
    chk("meta_v", 64'(cache_req_metadata_v_o), 64'd1);
    chk("meta_data", 64'(cache_req_metadata_o), mask[0] ? 64'h5A : 64'hC3);
    chk("meta_no_req_v", 64'(cache_req_v_o), 64'd0);
    tick();
    req0_metadata_v_i = 0; req1_metadata_v_i = 0;

    cache_req_critical_tag_i = 1; cache_req_critical_data_i = 1;
    @(negedge clk);
    chk("crit_tag", 64'({crit_tag1_o, crit_tag0_o}), 64'(mask));
    chk("crit_data", 64'({crit_data1_o, crit_data0_o}), 64'(mask));
    tick();
    cache_req_critical_tag_i = 0; cache_req_critical_data_i = 0;

    cache_req_complete_i = 1;
    req0_v_i = 1;
    @(negedge clk);
    got = {complete1_o, complete0_o};
    if (exp_q.size() == 0) chk("sb_underflow", 64'(got), 64'd0);
    else chk("complete", 64'(got), 64'(exp_q.pop_front()));
    chk("no_grant_on_complete", 64'(cache_req_v_o), 64'd0);
    tick();
    cache_req_complete_i = 0;
    req0_v_i = 0;
    chk("no_error", 64'(error_o), 64'd0);
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_req_v", 64'(cache_req_v_o), 64'd0);
    chk("rst_yumi", 64'({req1_yumi_o, req0_yumi_o}), 64'd0);
    chk("rst_meta_v", 64'(cache_req_metadata_v_o), 64'd0);
    chk("rst_ret", 64'({crit_tag1_o, crit_tag0_o, crit_data1_o, crit_data0_o,
                        complete1_o, complete0_o}), 64'd0);
    chk("rst_error", 64'(error_o), 64'd0);
    tick();

    run_txn(1, 0, 56'h8000_0040, 56'h0, 0, 0, 0);

    do_reset();
    for (int i = 0; i < 4; i++) run_txn(1, 1, 56'h1000, 56'h2000, 0, 0, 0);

    run_txn(1, 1, 56'h1040, 56'h1078, 0, 0, 0);
    run_txn(1, 1, 56'h1040, 56'h1078, 0, 1, 0);
    run_txn(1, 1, 56'h1040, 56'h1078, 0, 1, 0);
    run_txn(1, 0, 56'h3000, 56'h0, 0, 0, 5);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    // Stray completion in e_ready.
    cache_req_complete_i = 1;
    @(negedge clk);
    chk("stray_complete", 64'({complete1_o, complete0_o}), 64'd0);
    tick();
    cache_req_complete_i = 0;
    chk("error_set", 64'(error_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("error_sticky", 64'(error_o), 64'd1);
    end
    do_reset();
    chk("error_cleared", 64'(error_o), 64'd0);

    // Reset while a request is in flight, with a completion arriving in the reset cycle.
    req0_i = {8'hA0, 56'h4000}; req0_paddr_i = 56'h4000; req0_v_i = 1; cache_req_yumi_i = 1;
    tick();
    req0_v_i = 0; cache_req_yumi_i = 0;
    reset_i = 1; cache_req_complete_i = 1;
    @(negedge clk);
    chk("rst_mid_complete", 64'({complete1_o, complete0_o}), 64'd0);
    tick();
    reset_i = 0; cache_req_complete_i = 0;
    chk("rst_mid_error", 64'(error_o), 64'd0);
    req0_v_i = 1; req1_v_i = 1; req1_i = {8'hB1, 56'h5000}; req1_paddr_i = 56'h5000;
    @(negedge clk);
    chk("rst_mid_ready", 64'(cache_req_v_o), 64'd1);
    chk("rst_mid_lru", 64'(cache_req_o), 64'({8'hA0, 56'h4000}));
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
